// File: rtl/uart_pkt_ctrl_if.sv
// Byte-in / payload-out stream bundle for the UART packet controller.
// master = byte source and payload sink, slave = the controller.
interface uart_pkt_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output rx_data, rx_valid, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  rx_data, rx_valid, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/uart_pkt_ctrl.sv
// Frames SYNC/LEN/PAYLOAD/CHK packets from the UART byte stream, checks them
// and replays the buffered payload over a valid/ready stream.
module uart_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_pkt_ctrl_if.slave       bus,
    output logic                 pkt_ok,
    output logic                 err_len,
    output logic                 err_chk,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic [15:0]          drop_cnt
);
    localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              DEPTH     = 1 << AW;
    localparam int              TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMAX      = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    state_t          state_q;
    logic [7:0]      len_q;
    logic [7:0]      sum_q;
    logic [7:0]      wr_idx_q;
    logic [7:0]      rd_idx_q;
    logic [TW-1:0]   timer_q;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      out_data_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            pkt_ok_q;
    logic            err_len_q;
    logic            err_chk_q;
    logic            err_timeout_q;
    logic            err_overrun_q;
    logic [15:0]     drop_cnt_q;

    logic [7:0]      sum_d;
    logic [7:0]      rd_idx_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign sum_d    = sum_q + bus.rx_data;
    assign rd_idx_d = rd_idx_q + 8'd1;

    // Payload storage; contents are don't-care out of reset.
    always_ff @(posedge clk) begin
        if (state_q == S_PAYLOAD && bus.rx_valid) begin
            mem_q[wr_idx_q[AW-1:0]] <= bus.rx_data;
        end
    end

    // Packet framing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_HUNT;
            len_q         <= 8'd0;
            sum_q         <= 8'd0;
            wr_idx_q      <= 8'd0;
            rd_idx_q      <= 8'd0;
            timer_q       <= '0;
            out_data_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            pkt_ok_q      <= 1'b0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            drop_cnt_q    <= 16'd0;
        end else begin
            pkt_ok_q      <= 1'b0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            case (state_q)
                S_HUNT: begin
                    timer_q <= '0;
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        state_q <= S_LEN;
                    end
                end
                S_LEN, S_PAYLOAD, S_CHK: begin
                    // A byte arriving on the timeout cycle wins over the timeout.
                    if (bus.rx_valid) begin
                        timer_q <= '0;
                        case (state_q)
                            S_LEN: begin
                                if (bus.rx_data != 8'd0 && bus.rx_data <= MAX_LEN_B) begin
                                    len_q    <= bus.rx_data;
                                    sum_q    <= bus.rx_data;
                                    wr_idx_q <= 8'd0;
                                    state_q  <= S_PAYLOAD;
                                end else begin
                                    err_len_q  <= 1'b1;
                                    drop_cnt_q <= sat_inc(drop_cnt_q);
                                    state_q    <= S_HUNT;
                                end
                            end
                            S_PAYLOAD: begin
                                sum_q    <= sum_d;
                                wr_idx_q <= wr_idx_q + 8'd1;
                                if (wr_idx_q == len_q - 8'd1) begin
                                    state_q <= S_CHK;
                                end
                            end
                            default: begin
                                if (sum_d == 8'd0) begin
                                    pkt_ok_q    <= 1'b1;
                                    rd_idx_q    <= 8'd0;
                                    out_valid_q <= 1'b1;
                                    out_data_q  <= mem_q[AW'(0)];
                                    out_last_q  <= (len_q == 8'd1);
                                    state_q     <= S_SEND;
                                end else begin
                                    err_chk_q  <= 1'b1;
                                    drop_cnt_q <= sat_inc(drop_cnt_q);
                                    state_q    <= S_HUNT;
                                end
                            end
                        endcase
                    end else if (timer_q == TMAX) begin
                        err_timeout_q <= 1'b1;
                        drop_cnt_q    <= sat_inc(drop_cnt_q);
                        timer_q       <= '0;
                        state_q       <= S_HUNT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_SEND: begin
                    err_overrun_q <= bus.rx_valid;
                    if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= S_HUNT;
                        end else begin
                            rd_idx_q   <= rd_idx_d;
                            out_data_q <= mem_q[rd_idx_d[AW-1:0]];
                            out_last_q <= (rd_idx_d == len_q - 8'd1);
                        end
                    end
                end
                default: begin
                    state_q <= S_HUNT;
                end
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign pkt_ok        = pkt_ok_q;
    assign err_len       = err_len_q;
    assign err_chk       = err_chk_q;
    assign err_timeout   = err_timeout_q;
    assign err_overrun   = err_overrun_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: framing, checksum, length, timeout,
// backpressure/overrun and reset-during-send scenarios.
module tb_uart_pkt_ctrl;
    localparam int TO = 16;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_OK   = 5'b10000;
    localparam logic [4:0] F_LEN  = 5'b01000;
    localparam logic [4:0] F_CHK  = 5'b00100;
    localparam logic [4:0] F_TO   = 5'b00010;
    localparam logic [4:0] F_OVR  = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_ok, err_len, err_chk, err_timeout, err_overrun;
    logic [15:0] drop_cnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    uart_pkt_ctrl_if bus_if ();

    uart_pkt_ctrl #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN(64),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if),
        .pkt_ok(pkt_ok),
        .err_len(err_len),
        .err_chk(err_chk),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, pkt_ok, err_len, err_chk, err_timeout, err_overrun}, {27'd0, exp});
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
        check(tag, {22'd0, bus_if.out_valid, bus_if.out_data, bus_if.out_last}, {22'd0, v, d, l});
    endtask

    task automatic chk_idle(input string tag);
        check(tag, {31'd0, bus_if.out_valid}, 32'd0);
    endtask

    task automatic chk_drop(input string tag, input logic [15:0] exp);
        check(tag, {16'd0, drop_cnt}, {16'd0, exp});
    endtask

    // Called at a negedge; returns at the next negedge with the byte consumed.
    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic send_quiet(input string tag, input logic [7:0] b);
        send_byte(b);
        chk_flags(tag, F_NONE);
    endtask

    task automatic drain(input string tag, input logic [7:0] d, input logic l);
        chk_out(tag, 1'b1, d, l);
        @(negedge clk);
    endtask

    task automatic good_pkt(input string tag);
        bus_if.out_ready = 1'b1;
        send_quiet({tag, "_sync"}, 8'hA5);
        send_quiet({tag, "_len"}, 8'h03);
        send_quiet({tag, "_p0"}, 8'h11);
        send_quiet({tag, "_p1"}, 8'h22);
        send_quiet({tag, "_p2"}, 8'h33);
        send_byte(8'h97);
        chk_flags({tag, "_ok"}, F_OK);
        drain({tag, "_b0"}, 8'h11, 1'b0);
        chk_flags({tag, "_once"}, F_NONE);
        drain({tag, "_b1"}, 8'h22, 1'b0);
        drain({tag, "_b2"}, 8'h33, 1'b1);
        chk_idle({tag, "_end"});
    endtask

    logic [7:0] bp_data [6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33};
    logic       bp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       bp_rdy  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         xfers;

    initial begin
        bus_if.rx_data   = 8'h00;
        bus_if.rx_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        #12;
        chk_out("rst_out", 1'b0, 8'h00, 1'b0);
        chk_flags("rst_flags", F_NONE);
        chk_drop("rst_drop", 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        good_pkt("good1");
        chk_drop("good1_drop", 16'd0);

        bus_if.out_ready = 1'b1;
        send_quiet("bad_sync", 8'hA5);
        send_quiet("bad_len", 8'h03);
        send_quiet("bad_p0", 8'h11);
        send_quiet("bad_p1", 8'h22);
        send_quiet("bad_p2", 8'h33);
        send_byte(8'h98);
        chk_flags("bad_chk", F_CHK);
        chk_idle("bad_noout");
        chk_drop("bad_drop", 16'd1);
        @(negedge clk);
        chk_idle("bad_noout2");
        good_pkt("good2");

        send_quiet("len0_sync", 8'hA5);
        send_byte(8'h00);
        chk_flags("len0", F_LEN);
        send_quiet("len65_sync", 8'hA5);
        send_byte(8'h41);
        chk_flags("len65", F_LEN);
        chk_drop("len_drop", 16'd3);
        send_quiet("len_hunt_ignore", 8'h03);
        send_quiet("lensync_sync", 8'hA5);
        send_byte(8'hA5);
        chk_flags("len_is_sync", F_LEN);
        chk_drop("len_drop2", 16'd4);

        send_quiet("to_sync", 8'hA5);
        send_quiet("to_len", 8'h02);
        send_quiet("to_p0", 8'h11);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            chk_flags($sformatf("to_cyc%0d", i), (i == 16) ? F_TO : F_NONE);
        end
        chk_drop("to_drop", 16'd5);
        send_quiet("to_hunt_ignore", 8'h11);

        send_quiet("nto_sync", 8'hA5);
        send_quiet("nto_len", 8'h02);
        send_quiet("nto_p0", 8'h11);
        repeat (15) @(negedge clk);
        chk_flags("nto_wait", F_NONE);
        send_quiet("nto_p1_last_cycle", 8'h22);
        send_byte(8'hCB);
        chk_flags("nto_ok", F_OK);
        drain("nto_b0", 8'h11, 1'b0);
        drain("nto_b1", 8'h22, 1'b1);
        chk_idle("nto_end");
        chk_drop("nto_drop", 16'd5);

        send_quiet("max_sync", 8'hA5);
        send_quiet("max_len", 8'h40);
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i));
        end
        chk_flags("max_payload_quiet", F_NONE);
        send_byte(8'hE0);
        chk_flags("max_ok", F_OK);
        for (int i = 0; i < 64; i++) begin
            drain($sformatf("max_b%0d", i), 8'(i), (i == 63));
        end
        chk_idle("max_end");

        bus_if.out_ready = 1'b0;
        send_quiet("bp_sync", 8'hA5);
        send_quiet("bp_len", 8'h03);
        send_quiet("bp_p0", 8'h11);
        send_quiet("bp_p1", 8'h22);
        send_quiet("bp_p2", 8'h33);
        send_byte(8'h97);
        chk_flags("bp_ok", F_OK);
        xfers = 0;
        for (int k = 0; k < 6; k++) begin
            chk_out($sformatf("bp_out%0d", k), 1'b1, bp_data[k], bp_last[k]);
            if (k == 3) begin
                chk_flags("bp_overrun", F_OVR);
            end else if (k > 0) begin
                chk_flags($sformatf("bp_flags%0d", k), F_NONE);
            end
            bus_if.out_ready = bp_rdy[k];
            if (bus_if.out_valid && bp_rdy[k]) begin
                xfers++;
            end
            bus_if.rx_data  = 8'hA5;
            bus_if.rx_valid = (k == 2);
            @(negedge clk);
        end
        bus_if.rx_valid = 1'b0;
        chk_idle("bp_end");
        check("bp_xfers", 32'(xfers), 32'd3);
        chk_drop("bp_drop", 16'd5);

        bus_if.out_ready = 1'b1;
        send_quiet("rs_sync", 8'hA5);
        send_quiet("rs_len", 8'h03);
        send_quiet("rs_p0", 8'h11);
        send_quiet("rs_p1", 8'h22);
        send_quiet("rs_p2", 8'h33);
        send_byte(8'h97);
        drain("rs_b0", 8'h11, 1'b0);
        chk_out("rs_b1", 1'b1, 8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("rs_async", 1'b0, 8'h00, 1'b0);
        chk_drop("rs_drop", 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_quiet("one_sync", 8'hA5);
        send_quiet("one_len", 8'h01);
        send_quiet("one_p0", 8'h7F);
        send_byte(8'h80);
        chk_flags("one_ok", F_OK);
        drain("one_b0", 8'h7F, 1'b1);
        chk_idle("one_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
